// File: rtl/i2s_rx_framer.sv
// Multi-line I2S receiver: oversamples sck/ws/sd in the ck domain, deserialises one word
// per line per slot and bursts each slot's words into the input RAM at {frame, channel}.
module i2s_rx_framer #(
   parameter int LINES    = 8,
   parameter int FRAMES   = 32,
   parameter int SAMPLE_W = 16,
   localparam int CHAN_W  = $clog2(2 * LINES),
   localparam int FRAME_W = $clog2(FRAMES),
   localparam int ADDR_W  = CHAN_W + FRAME_W
) (
   input  logic                ck,
   input  logic                rst,
   input  logic                sck,
   input  logic                ws,
   input  logic [LINES-1:0]    sd,
   output logic                audio_we,
   output logic [ADDR_W-1:0]   audio_waddr,
   output logic [SAMPLE_W-1:0] audio_wdata,
   output logic [FRAME_W-1:0]  frame,
   output logic                frame_done,
   output logic                synced,
   output logic                overrun
);

   localparam int IDX_W = CHAN_W - 1;
   localparam int CNT_W = $clog2(SAMPLE_W + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

   typedef enum logic {SYNC, RUN} sync_e;
   typedef enum logic {IDLE, WRITE} burst_e;

   logic [1:0]       sck_sync_q, ws_sync_q;
   logic [LINES-1:0] sd_sync1_q, sd_sync2_q;
   logic             sck_prev_q;
   logic             sck_edge, ws_s;
   logic [LINES-1:0] sd_s;

   sync_e                         sync_state_q, sync_state_d;
   logic                          ws_prev_q, ws_prev_d;
   logic [CNT_W-1:0]              bit_cnt_q, bit_cnt_d;
   logic [LINES-1:0][SAMPLE_W-1:0] shift_q, shift_d, shift_nx;
   logic                          word_done;

   burst_e                         burst_q, burst_d;
   logic [IDX_W-1:0]               idx_q, idx_d, idx_nx;
   logic [LINES-1:0][SAMPLE_W-1:0] hold_q, hold_d;
   logic                           side_q, side_d;
   logic                           we_q, we_d;
   logic [ADDR_W-1:0]              waddr_q, waddr_d;
   logic [SAMPLE_W-1:0]            wdata_q, wdata_d;
   logic [FRAME_W-1:0]             frame_q, frame_d, fill_q, fill_d;
   logic                           done_q, done_d, overrun_q, overrun_d;

   assign sck_edge = sck_sync_q[1] & ~sck_prev_q;
   assign ws_s     = ws_sync_q[1];
   assign sd_s     = sd_sync2_q;
   assign idx_nx   = idx_q + 1'b1;

   // Candidate shift contents if this edge captures a bit on every line.
   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_line
         assign shift_nx[gi] = {shift_q[gi][SAMPLE_W-2:0], sd_s[gi]};
      end
   endgenerate

   function automatic logic [CHAN_W-1:0] chan_of(input logic [IDX_W-1:0] i, input logic s);
      return {i, s};
   endfunction

   always_comb begin
      sync_state_d = sync_state_q;
      ws_prev_d    = ws_prev_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      word_done    = 1'b0;
      if (sck_edge) begin
         ws_prev_d = ws_s;
         if (ws_s != ws_prev_q) begin
            // Transition edge: the MSB arrives on the following edge.
            bit_cnt_d = '0;
            if (sync_state_q == SYNC && !ws_s) sync_state_d = RUN;
         end else if (sync_state_q == RUN && bit_cnt_q < CNT_W'(SAMPLE_W)) begin
            shift_d   = shift_nx;
            bit_cnt_d = bit_cnt_q + 1'b1;
            word_done = (bit_cnt_q == CNT_W'(SAMPLE_W - 1));
         end
      end
   end

   always_comb begin
      burst_d   = burst_q;
      idx_d     = idx_q;
      hold_d    = hold_q;
      side_d    = side_q;
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      frame_d   = frame_q;
      fill_d    = fill_q;
      done_d    = 1'b0;
      overrun_d = overrun_q;
      case (burst_q)
         IDLE: begin
            if (word_done) begin
               // First write is issued straight from the freshly completed word.
               hold_d  = shift_nx;
               side_d  = ws_s;
               burst_d = WRITE;
               idx_d   = '0;
               we_d    = 1'b1;
               waddr_d = {fill_q, chan_of('0, ws_s)};
               wdata_d = shift_nx[0];
            end
         end
         WRITE: begin
            if (word_done) overrun_d = 1'b1;
            if (idx_q == LAST_IDX) begin
               burst_d = IDLE;
               if (side_q) begin
                  frame_d = fill_q;
                  fill_d  = (fill_q == FRAME_W'(FRAMES - 1)) ? '0 : fill_q + 1'b1;
                  done_d  = 1'b1;
               end
            end else begin
               idx_d   = idx_nx;
               we_d    = 1'b1;
               waddr_d = {fill_q, chan_of(idx_nx, side_q)};
               wdata_d = hold_q[idx_nx];
            end
         end
         default: burst_d = IDLE;
      endcase
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         sck_sync_q   <= '0;
         ws_sync_q    <= '0;
         sd_sync1_q   <= '0;
         sd_sync2_q   <= '0;
         sck_prev_q   <= 1'b0;
         sync_state_q <= SYNC;
         ws_prev_q    <= 1'b0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         burst_q      <= IDLE;
         idx_q        <= '0;
         hold_q       <= '0;
         side_q       <= 1'b0;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         frame_q      <= FRAME_W'(FRAMES - 1);
         fill_q       <= '0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         sck_sync_q   <= {sck_sync_q[0], sck};
         ws_sync_q    <= {ws_sync_q[0], ws};
         sd_sync1_q   <= sd;
         sd_sync2_q   <= sd_sync1_q;
         sck_prev_q   <= sck_sync_q[1];
         sync_state_q <= sync_state_d;
         ws_prev_q    <= ws_prev_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         burst_q      <= burst_d;
         idx_q        <= idx_d;
         hold_q       <= hold_d;
         side_q       <= side_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         frame_q      <= frame_d;
         fill_q       <= fill_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign audio_we    = we_q;
   assign audio_waddr = waddr_q;
   assign audio_wdata = wdata_q;
   assign frame       = frame_q;
   assign frame_done  = done_q;
   assign synced      = (sync_state_q == RUN);
   assign overrun     = overrun_q;

endmodule
